blink_rate_detector: RTL and testbench

- Receive-side counterpart of the programmable blinker: it watches a blinking light signal and recovers the rate setting that produced it.
- Counts base ticks between successive toggles of the light and decodes the half-period (1, 2, 4 or 8 ticks) back to the 4-bit one-hot shift code.
- Reports lock when the rate is stable, and flags malformed or stalled blinking.
- Sits in the self-check path next to the blinker, driven from the same clk and tick enable.

---
 rtl/blink_rate_detector.sv | 138 +++++++++++++
 tb/tb_blink_rate_detector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_detector.sv
// Recovers the one-hot rate code of a blinking light by counting ticks between toggles.
// Optional 2-flop input synchroniser: define BLINK_DETECT_SYNC_EN.
module blink_rate_detector #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       light_in,
    input  logic       tick,
    output logic [3:0] rate,
    output logic       rate_valid,
    output logic       locked,
    output logic       err,
    output logic       timeout
);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [CNT_W:0]   meas;
    logic             light_s, light_d, edge_det;
    logic             timeout_hit;
    logic [3:0]       code, prev_code;
    logic             legal;
    logic [3:0]       rate_nx, prev_nx;
    logic             valid_nx, locked_nx, err_nx, to_nx;

`ifdef BLINK_DETECT_SYNC_EN
    logic sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= light_in;
            sync2 <= sync1;
        end
    end

    assign light_s = sync2;
`else
    assign light_s = light_in;
`endif

    assign edge_det = light_s ^ light_d;

    // A tick landing on the closing edge belongs to the period it closes.
    assign meas        = {1'b0, cnt} + {{CNT_W{1'b0}}, tick};
    assign timeout_hit = ({1'b0, cnt} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT);
    assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        code = 4'b0000;
        case (meas)
            (CNT_W+1)'(1): code = 4'b0001;
            (CNT_W+1)'(2): code = 4'b0010;
            (CNT_W+1)'(4): code = 4'b0100;
            (CNT_W+1)'(8): code = 4'b1000;
            default:       code = 4'b0000;
        endcase
    end

    assign legal = (code != 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            light_d    <= 1'b0;
            rate       <= 4'b0000;
            rate_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            prev_code  <= 4'b0000;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            light_d    <= light_s;
            rate       <= rate_nx;
            rate_valid <= valid_nx;
            locked     <= locked_nx;
            err        <= err_nx;
            timeout    <= to_nx;
            prev_code  <= prev_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rate_nx   = rate;
        locked_nx = locked;
        prev_nx   = prev_code;
        valid_nx  = 1'b0;
        err_nx    = 1'b0;
        to_nx     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (edge_det) state_nx = MEASURE;
            end
            MEASURE: begin
                if (edge_det) begin
                    cnt_nx = '0;
                    if (legal) begin
                        rate_nx   = code;
                        valid_nx  = 1'b1;
                        locked_nx = (code == prev_code);
                        prev_nx   = code;
                    end else begin
                        err_nx    = 1'b1;
                        rate_nx   = 4'b0000;
                        locked_nx = 1'b0;
                        prev_nx   = 4'b0000;
                    end
                end else if (tick) begin
                    if (timeout_hit) begin
                        // A stall forgets the last code, so relock needs two fresh matches.
                        state_nx  = IDLE;
                        cnt_nx    = '0;
                        to_nx     = 1'b1;
                        rate_nx   = 4'b0000;
                        locked_nx = 1'b0;
                        prev_nx   = 4'b0000;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_blink_rate_detector.sv
// Bench for blink_rate_detector: tick-timestamp reference model, directed literal checks, random soak.
module tb_blink_rate_detector;

    localparam int TIMEOUT = 32;
`ifdef BLINK_DETECT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       light_in = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] rate;
    logic       rate_valid, locked, err, timeout;

    blink_rate_detector #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .light_in(light_in), .tick(tick),
        .rate(rate), .rate_valid(rate_valid), .locked(locked),
        .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit started = 0;

    // Reference model: periods measured as differences of a running tick count.
    bit   m_meas, m_lprev, m_h1, m_h2;
    int   m_total, m_start;
    logic [3:0] m_prev;
    logic [3:0] exp_rate;
    logic exp_valid, exp_locked, exp_err, exp_to;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_meas = 0; m_lprev = 0; m_h1 = 0; m_h2 = 0;
        m_total = 0; m_start = 0; m_prev = 4'b0000;
        exp_rate = 4'b0000; exp_valid = 0; exp_locked = 0; exp_err = 0; exp_to = 0;
    endtask

    task automatic model_step();
        bit ls, e;
        int m;
`ifdef BLINK_DETECT_SYNC_EN
        ls = m_h2; m_h2 = m_h1; m_h1 = light_in;
`else
        ls = light_in;
`endif
        e = (ls != m_lprev);
        m_lprev = ls;
        if (tick) m_total++;
        exp_valid = 0; exp_err = 0; exp_to = 0;
        if (!m_meas) begin
            if (e) begin
                m_meas = 1;
                m_start = m_total;
            end
        end else if (e) begin
            m = m_total - m_start;
            m_start = m_total;
            if (m == 1 || m == 2 || m == 4 || m == 8) begin
                exp_rate   = 4'(m);
                exp_valid  = 1;
                exp_locked = (m_prev == 4'(m));
                m_prev     = 4'(m);
            end else begin
                exp_err = 1; exp_rate = 4'b0000; exp_locked = 0; m_prev = 4'b0000;
            end
        end else if (tick && (m_total - m_start == TIMEOUT)) begin
            m_meas = 0;
            exp_to = 1; exp_rate = 4'b0000; exp_locked = 0; m_prev = 4'b0000;
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("rate", int'(rate), int'(exp_rate));
            chk("rate_valid", int'(rate_valid), int'(exp_valid));
            chk("locked", int'(locked), int'(exp_locked));
            chk("err", int'(err), int'(exp_err));
            chk("timeout", int'(timeout), int'(exp_to));
        end
    end

    task automatic step(input bit l, input bit t, input bit r);
        light_in = l; tick = t; rst = r;
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        #1;
    endtask

    bit cur = 0;
    int ph = 0;

    // Run n ticks (tick every 3rd clk); when flip, toggle the light on the n-th tick.
    task automatic half(input int n, input bit flip);
        int k = 0;
        bit t, l;
        l = cur;
        while (k < n) begin
            t = (ph % 3 == 2);
            ph++;
            if (t) k++;
            l = (flip && t && k == n) ? ~cur : cur;
            step(l, t, 1'b0);
        end
        cur = l;
        if (flip) for (int i = 0; i < LAT - 1; i++) step(cur, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        started = 1;
        chk("reset_rate", int'(rate), 0);
        chk("reset_locked", int'(locked), 0);
        step(1'b0, 1'b0, 1'b0);

        half(4, 1); chk("first_toggle_valid", int'(rate_valid), 0);
                    chk("first_toggle_rate", int'(rate), 0);
        half(4, 1); chk("r4_rate", int'(rate), 4);
                    chk("r4_valid", int'(rate_valid), 1);
                    chk("r4_unlocked", int'(locked), 0);
        half(4, 1); chk("r4_locked", int'(locked), 1);
        half(2, 1); chk("r2_rate", int'(rate), 2);
                    chk("r2_unlocked", int'(locked), 0);
        half(2, 1); chk("r2_locked", int'(locked), 1);
        half(8, 1); chk("r8_rate", int'(rate), 8);
                    chk("r8_unlocked", int'(locked), 0);
        half(8, 1); chk("r8_locked", int'(locked), 1);
        half(1, 1); half(1, 1);
                    chk("r1_rate", int'(rate), 1);
                    chk("r1_locked", int'(locked), 1);
        half(3, 1); chk("p3_err", int'(err), 1);
                    chk("p3_rate", int'(rate), 0);
                    chk("p3_locked", int'(locked), 0);
                    chk("p3_valid", int'(rate_valid), 0);
        half(4, 1); chk("after_err_rate", int'(rate), 4);
        half(TIMEOUT, 0);
                    chk("to_pulse", int'(timeout), 1);
                    chk("to_rate", int'(rate), 0);
        half(4, 1); chk("post_to_first_valid", int'(rate_valid), 0);
        half(4, 1); chk("post_to_valid", int'(rate_valid), 1);
                    chk("post_to_rate", int'(rate), 4);
        half(4, 1); chk("relock", int'(locked), 1);
        half(2, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_rate", int'(rate), 0);
        cur = 0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        half(4, 1); chk("post_rst_first_valid", int'(rate_valid), 0);
        half(4, 1); chk("post_rst_valid", int'(rate_valid), 1);
                    chk("post_rst_rate", int'(rate), 4);

        for (int seg = 0; seg < 16; seg++) begin
            int div;
            case ($urandom_range(0, 3))
                0: div = 2;
                1: div = 6;
                2: div = 20;
                default: div = 150;
            endcase
            for (int c = 0; c < 250; c++) begin
                bit t, l, r;
                t = ($urandom_range(0, 2) == 0);
                l = ($urandom_range(0, div - 1) == 0) ? ~cur : cur;
                r = ($urandom_range(0, 599) == 0);
                cur = l;
                step(l, t, r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
